// File: rtl/mig_app_pkg.sv
// Shared definitions for the MIG application-interface responder model.
package mig_app_pkg;

    localparam int APP_ADDR_W  = 30;
    localparam int APP_DATA_W  = 256;
    localparam int APP_MASK_W  = 32;
    localparam int APP_CMD_W   = 3;
    // One write-data FIFO entry is {mask, data}.
    localparam int WDF_ENTRY_W = APP_MASK_W + APP_DATA_W;

    typedef enum logic [APP_CMD_W-1:0] {
        DRAM_WRITE = 3'b000,
        DRAM_READ  = 3'b001
    } dram_cmd_e;

    // Merge a beat into a stored word; a mask bit of 1 keeps the old byte.
    function automatic logic [APP_DATA_W-1:0] byte_merge(
        input logic [APP_DATA_W-1:0] old_word,
        input logic [APP_DATA_W-1:0] new_word,
        input logic [APP_MASK_W-1:0] mask
    );
        logic [APP_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < APP_MASK_W; b++) begin
            if (!mask[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mig_wdf_fifo.sv
// Two-entry write-data FIFO holding {mask, data} beats ahead of their commands.
module mig_wdf_fifo
    import mig_app_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WDF_ENTRY_W-1:0] push_entry,
    input  logic                   pop,
    output logic [WDF_ENTRY_W-1:0] pop_entry,
    output logic                   full,
    output logic                   empty
);

    logic [WDF_ENTRY_W-1:0] slots [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    // Entry payload needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_entry;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign pop_entry = slots[rd_ptr];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for a MIG DDR application port: calibration delay,
// optional command-ready stalls, byte-masked writes, fixed-latency reads.
//
// Handshakes: a command transfers in a cycle where app_en & app_rdy, a write
// beat where app_wdf_wren & app_wdf_rdy; holding the request while the ready
// is low is safe and transfers exactly once. Reads have no backpressure.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int MEM_AW          = 10,
    parameter int RD_LATENCY      = 4,
    parameter int CALIB_CYCLES    = 64,
    parameter int RDY_STALL_EVERY = 0
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    output logic                  calib_done,
    input  logic                  app_en,
    input  logic [APP_CMD_W-1:0]  app_cmd,
    input  logic [APP_ADDR_W-1:0] app_addr,
    output logic                  app_rdy,
    input  logic                  app_wdf_wren,
    input  logic [APP_DATA_W-1:0] app_wdf_data,
    input  logic                  app_wdf_end,
    input  logic [APP_MASK_W-1:0] app_wdf_mask,
    output logic                  app_wdf_rdy,
    output logic [APP_DATA_W-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  illegal_cmd
);

    localparam int CALIB_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int STALL_W = (RDY_STALL_EVERY > 1) ? $clog2(RDY_STALL_EVERY) : 1;

    logic [CALIB_W-1:0]     calib_cnt;
    logic [STALL_W-1:0]     stall_cnt;
    logic                   stall_cycle;
    logic                   pending_write;
    logic [MEM_AW-1:0]      pending_idx;
    logic [MEM_AW-1:0]      cmd_idx;
    logic [MEM_AW-1:0]      wr_idx;
    logic                   cmd_accept, rd_accept, wr_accept, bad_accept;
    logic                   wdf_accept, data_avail, wr_need, wr_commit;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WDF_ENTRY_W-1:0] fifo_head, wr_entry;
    logic                   unused_bits;

    logic [APP_DATA_W-1:0]  mem [2**MEM_AW];
    logic [RD_LATENCY-1:0]  rd_vld_pipe;
    logic [APP_DATA_W-1:0]  rd_data_pipe [RD_LATENCY];

    // Beat-end and low/aliased address bits carry no information here.
    assign unused_bits = ^{app_wdf_end, app_addr[2:0], app_addr[APP_ADDR_W-1:3+MEM_AW]};

    // Calibration: count clocks after reset release, then hold done.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            calib_cnt  <= '0;
            calib_done <= 1'b0;
        end else if (!calib_done) begin
            if (calib_cnt == CALIB_W'(CALIB_CYCLES - 1)) calib_done <= 1'b1;
            else                                         calib_cnt  <= calib_cnt + 1'b1;
        end
    end

    // Free-running stall phase; the last phase of each period drops app_rdy.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                   stall_cnt <= '0;
        else if (RDY_STALL_EVERY > 1) stall_cnt <= (stall_cnt == STALL_W'(RDY_STALL_EVERY - 1))
                                                   ? '0 : stall_cnt + 1'b1;
    end

    assign stall_cycle = (RDY_STALL_EVERY != 0) &&
                         (stall_cnt == STALL_W'(RDY_STALL_EVERY - 1));

    assign app_rdy     = calib_done & ~pending_write & ~stall_cycle;
    assign app_wdf_rdy = calib_done & ~fifo_full;

    assign cmd_idx    = app_addr[3 +: MEM_AW];
    assign cmd_accept = app_en & app_rdy;
    assign rd_accept  = cmd_accept & (app_cmd == DRAM_READ);
    assign wr_accept  = cmd_accept & (app_cmd == DRAM_WRITE);
    assign bad_accept = cmd_accept & ~rd_accept & ~wr_accept;

    // A write commits as soon as it has data: from the FIFO head if present,
    // otherwise straight from a beat arriving this cycle (that beat bypasses
    // the FIFO). With app_rdy low while pending, a new write and a pending
    // one never coexist, so write order equals command order.
    assign wdf_accept = app_wdf_wren & app_wdf_rdy;
    assign data_avail = ~fifo_empty | wdf_accept;
    assign wr_need    = pending_write | wr_accept;
    assign wr_commit  = wr_need & data_avail;
    assign wr_idx     = pending_write ? pending_idx : cmd_idx;
    assign wr_entry   = fifo_empty ? {app_wdf_mask, app_wdf_data} : fifo_head;
    assign fifo_pop   = wr_commit & ~fifo_empty;
    assign fifo_push  = wdf_accept & ~(wr_commit & fifo_empty);

    mig_wdf_fifo u_wdf_fifo (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry ({app_wdf_mask, app_wdf_data}),
        .pop        (fifo_pop),
        .pop_entry  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Track the single write command still waiting for its data beat.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_write <= 1'b0;
            pending_idx   <= '0;
        end else begin
            pending_write <= wr_need & ~data_avail;
            if (wr_accept) pending_idx <= cmd_idx;
        end
    end

    // Sticky flag for any command that is neither read nor write.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)          illegal_cmd <= 1'b0;
        else if (bad_accept) illegal_cmd <= 1'b1;
    end

    // Backing storage keeps its contents across reset.
    always_ff @(posedge sys_clk) begin
        if (wr_commit) begin
            mem[wr_idx] <= byte_merge(mem[wr_idx], wr_entry[APP_DATA_W-1:0],
                                      wr_entry[WDF_ENTRY_W-1 -: APP_MASK_W]);
        end
    end

    // Read pipeline: storage is sampled at acceptance; idle stages carry zero.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_data_pipe[i] <= '0;
        end else begin
            rd_vld_pipe[0]  <= rd_accept;
            rd_data_pipe[0] <= rd_accept ? mem[cmd_idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
                rd_data_pipe[i] <= rd_data_pipe[i-1];
            end
        end
    end

    assign app_rd_data_valid = rd_vld_pipe[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld_pipe[RD_LATENCY-1];
    assign app_rd_data       = rd_data_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: one default instance and one with
// command-ready stalls every third cycle.
module tb_mig_app_responder;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic         calib_done, app_rdy, app_wdf_rdy;
    logic         app_rd_data_valid, app_rd_data_end, illegal_cmd;
    logic [255:0] app_rd_data;
    logic         app_en = 1'b0;
    logic [2:0]   app_cmd = 3'b000;
    logic [29:0]  app_addr = '0;
    logic         app_wdf_wren = 1'b0;
    logic [255:0] app_wdf_data = '0;
    logic         app_wdf_end = 1'b0;
    logic [31:0]  app_wdf_mask = '0;

    mig_app_responder dut (
        .sys_clk           (clk),
        .rst_n             (rst_n),
        .calib_done        (calib_done),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rdy           (app_rdy),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_mask      (app_wdf_mask),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .app_rd_data_end   (app_rd_data_end),
        .illegal_cmd       (illegal_cmd)
    );

    // ---------------- stalling instance ----------------
    logic         s_calib_done, s_app_rdy, s_app_wdf_rdy;
    logic         s_rd_valid, s_rd_end, s_illegal_cmd;
    logic [255:0] s_rd_data;
    logic         s_app_en = 1'b0;
    logic [2:0]   s_app_cmd = 3'b000;
    logic [29:0]  s_app_addr = '0;

    mig_app_responder #(.RDY_STALL_EVERY(3)) dut_stall (
        .sys_clk           (clk),
        .rst_n             (rst_n),
        .calib_done        (s_calib_done),
        .app_en            (s_app_en),
        .app_cmd           (s_app_cmd),
        .app_addr          (s_app_addr),
        .app_rdy           (s_app_rdy),
        .app_wdf_wren      (1'b0),
        .app_wdf_data      (256'd0),
        .app_wdf_end       (1'b0),
        .app_wdf_mask      (32'd0),
        .app_wdf_rdy       (s_app_wdf_rdy),
        .app_rd_data       (s_rd_data),
        .app_rd_data_valid (s_rd_valid),
        .app_rd_data_end   (s_rd_end),
        .illegal_cmd       (s_illegal_cmd)
    );

    // ---------------- checking helpers ----------------
    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a command until it is accepted; returns just after the accept edge.
    task automatic issue_cmd(input logic [2:0] c, input logic [29:0] a);
        int budget = 0;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        while (!app_rdy && budget < 100) begin
            step();
            budget++;
        end
        check1("cmd_accept_in_time", budget < 100, 1'b1);
        step();
        app_en = 1'b0;
    endtask

    // Hold a write beat until it is accepted.
    task automatic issue_data(input logic [255:0] d, input logic [31:0] m);
        int budget = 0;
        app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1;
        while (!app_wdf_rdy && budget < 100) begin
            step();
            budget++;
        end
        check1("wdf_accept_in_time", budget < 100, 1'b1);
        step();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    // Read one word and check the 4-cycle return timing and data.
    task automatic read_expect(input string tag, input logic [29:0] a, input logic [255:0] exp);
        issue_cmd(3'b001, a);
        for (int k = 0; k < 3; k++) begin
            check1({tag, "_early_valid"}, app_rd_data_valid, 1'b0);
            step();
        end
        check1({tag, "_valid"}, app_rd_data_valid, 1'b1);
        check1({tag, "_end"}, app_rd_data_end, 1'b1);
        check256({tag, "_data"}, app_rd_data, exp);
        step();
        check1({tag, "_valid_drop"}, app_rd_data_valid, 1'b0);
        check256({tag, "_data_zero"}, app_rd_data, 256'd0);
    endtask

    function automatic logic [255:0] pat(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    // ---------------- directed sequence ----------------
    localparam logic [255:0] FILL_55  = {32{8'h55}};
    localparam logic [255:0] FILL_AA  = {32{8'hAA}};
    localparam logic [255:0] MASKED   = {{16{8'hAA}}, {16{8'h55}}};
    localparam logic [255:0] LATE_D   = {8{32'h1234_5678}};
    localparam logic [255:0] D30      = {8{32'h3030_3030}};
    localparam logic [255:0] D31      = {8{32'h3131_3131}};
    localparam logic [255:0] JUNK     = {8{32'hDEAD_BEEF}};

    initial begin
        int first_done;
        int early_rdy;
        int seen;
        int lows;
        int low_pos [3];
        int budget;

        // Reset state
        repeat (3) step();
        check1("rst_calib_done", calib_done, 1'b0);
        check1("rst_app_rdy", app_rdy, 1'b0);
        check1("rst_wdf_rdy", app_wdf_rdy, 1'b0);
        check1("rst_rd_valid", app_rd_data_valid, 1'b0);
        check1("rst_rd_end", app_rd_data_end, 1'b0);
        check256("rst_rd_data", app_rd_data, 256'd0);
        check1("rst_illegal", illegal_cmd, 1'b0);

        // Calibration: done after exactly 64 edges, readies low until then
        rst_n = 1'b1;
        first_done = 0;
        early_rdy = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (calib_done) begin
                first_done = i;
                break;
            end
            if (app_rdy || app_wdf_rdy) early_rdy = 1;
        end
        check_int("calib_edges", first_done, 64);
        check_int("calib_rdy_early", early_rdy, 0);
        check1("calib_app_rdy", app_rdy, 1'b1);
        check1("calib_wdf_rdy", app_wdf_rdy, 1'b1);

        // Write command and beat in the same cycle, empty FIFO
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 30'h10;
        app_wdf_wren = 1'b1; app_wdf_data = FILL_55; app_wdf_mask = 32'h0; app_wdf_end = 1'b1;
        check1("same_cycle_rdy", app_rdy, 1'b1);
        step();
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        check1("same_cycle_no_pending", app_rdy, 1'b1);

        // Masked write, data ahead of command
        issue_data(FILL_AA, 32'h0000_FFFF);
        issue_cmd(3'b000, 30'h10);
        check1("masked_no_pending", app_rdy, 1'b1);
        read_expect("masked", 30'h10, MASKED);

        // Late data: command waits three cycles for its beat
        issue_cmd(3'b000, 30'h100);
        check1("late_rdy_c1", app_rdy, 1'b0);
        step();
        check1("late_rdy_c2", app_rdy, 1'b0);
        step();
        app_wdf_wren = 1'b1; app_wdf_data = LATE_D; app_wdf_mask = 32'h0; app_wdf_end = 1'b1;
        check1("late_rdy_c3", app_rdy, 1'b0);
        check1("late_wdf_rdy", app_wdf_rdy, 1'b1);
        step();
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        check1("late_released", app_rdy, 1'b1);
        read_expect("late", 30'h100, LATE_D);

        // FIFO fills at two beats; a beat offered while full is dropped
        issue_data(D30, 32'h0);
        issue_data(D31, 32'h0);
        check1("fifo_full", app_wdf_rdy, 1'b0);
        app_wdf_wren = 1'b1; app_wdf_data = JUNK; app_wdf_mask = 32'h0;
        step();
        app_wdf_wren = 1'b0;
        issue_cmd(3'b000, 30'h180);
        issue_cmd(3'b000, 30'h188);
        check1("fifo_drained_app_rdy", app_rdy, 1'b1);
        check1("fifo_drained_wdf_rdy", app_wdf_rdy, 1'b1);
        read_expect("fifo0", 30'h180, D30);
        read_expect("fifo1", 30'h188, D31);

        // Streaming: eight back-to-back reads return eight adjacent beats
        for (int i = 0; i < 8; i++) begin
            issue_data(pat(i), 32'h0);
            issue_cmd(3'b000, 30'(i * 8));
        end
        for (int j = 0; j <= 12; j++) begin
            if (j < 8) begin
                app_en = 1'b1; app_cmd = 3'b001; app_addr = 30'(j * 8);
                check1("stream_rdy", app_rdy, 1'b1);
            end else begin
                app_en = 1'b0;
            end
            check1("stream_valid", app_rd_data_valid, (j >= 4) && (j <= 11));
            check256("stream_data", app_rd_data, ((j >= 4) && (j <= 11)) ? pat(j - 4) : 256'd0);
            step();
        end
        app_en = 1'b0;

        // Address aliasing: low 3 bits and bits above the index are ignored
        read_expect("alias", 30'h2017, pat(2));

        // Illegal command is dropped (the queued beat stays unused) and sticks
        check1("illegal_before", illegal_cmd, 1'b0);
        issue_data(JUNK, 32'h0);
        issue_cmd(3'b111, 30'h10);
        check1("illegal_set", illegal_cmd, 1'b1);
        check1("illegal_app_rdy", app_rdy, 1'b1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (app_rd_data_valid) seen++;
            step();
        end
        check_int("illegal_no_read", seen, 0);
        check1("illegal_sticky", illegal_cmd, 1'b1);

        // Reset with two reads in flight
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 30'h0;
        step();
        app_addr = 30'h8;
        step();
        app_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check1("midrst_valid", app_rd_data_valid, 1'b0);
        check256("midrst_data", app_rd_data, 256'd0);
        check1("midrst_illegal", illegal_cmd, 1'b0);
        check1("midrst_calib", calib_done, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            step();
            if (app_rd_data_valid) seen++;
        end
        check_int("midrst_no_valid", seen, 0);
        check1("midrst_recal", calib_done, 1'b1);
        check1("midrst_fifo_empty", app_wdf_rdy, 1'b1);

        // Storage survives reset; the dropped illegal command wrote nothing
        read_expect("kept_w2", 30'h10, pat(2));
        read_expect("kept_late", 30'h100, LATE_D);

        // Stalling instance: app_rdy low exactly one cycle in three
        check1("stall_calib", s_calib_done, 1'b1);
        check1("stall_wdf_rdy", s_app_wdf_rdy, 1'b1);
        check1("stall_illegal", s_illegal_cmd, 1'b0);
        lows = 0;
        for (int k = 0; k < 9; k++) begin
            if (!s_app_rdy) begin
                if (lows < 3) low_pos[lows] = k;
                lows++;
            end
            if (!s_rd_valid && s_rd_data != 256'd0) lows = 100;
            step();
        end
        check_int("stall_low_count", lows, 3);
        check_int("stall_spacing_a", low_pos[1] - low_pos[0], 3);
        check_int("stall_spacing_b", low_pos[2] - low_pos[1], 3);

        // Command held through a stall cycle is accepted once
        budget = 0;
        while (s_app_rdy && budget < 10) begin
            step();
            budget++;
        end
        check1("stall_found", budget < 10, 1'b1);
        s_app_en = 1'b1; s_app_cmd = 3'b001; s_app_addr = 30'h0;
        step();
        check1("stall_then_rdy", s_app_rdy, 1'b1);
        step();
        s_app_en = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (s_rd_valid && s_rd_end) seen++;
            step();
        end
        check_int("stall_single_accept", seen, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
